// File: rtl/rt_bcd_counter.sv
// rt_bcd_counter: real-time modulo-N up/down counter driven by an internal
// prescaler (DIV = CLK_HZ/TICK_HZ clocks per step). The count is presented
// as binary and as packed BCD, and both outputs are registered on the same
// edge so that they always agree.
//
// Optional feature macro: RTC_LAP_EN adds a lap capture register.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   en         run enable; prescaler and count hold while low
//   up         1 = count up, 0 = count down, sampled at each tick
//   clr        synchronous clear of count and prescaler (highest priority)
//   load       synchronous load strobe; load_val is clamped to N-1
//   load_val   binary load value
//   tick_o     one-cycle pulse, high while a freshly stepped count is shown
//   count_bin  binary count, 0..N-1
//   count_bcd  BCD count; digit i at [4i+3:4i]
//   tc         one-cycle pulse, high while a freshly wrapped count is shown
//   lap        (RTC_LAP_EN) capture strobe
//   lap_bcd    (RTC_LAP_EN) captured BCD count
//   lap_valid  (RTC_LAP_EN) set by a capture, cleared by clr
module rt_bcd_counter #(
  parameter int  CLK_HZ  = 100_000_000,
  parameter int  TICK_HZ = 1,
  parameter int  N       = 100,
  parameter int  DIGITS  = 2,
  localparam int W       = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [W-1:0]          load_val,
  output logic                  tick_o,
  output logic [W-1:0]          count_bin,
  output logic [4*DIGITS-1:0]   count_bcd,
`ifdef RTC_LAP_EN
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   lap_bcd,
  output logic                  lap_valid,
`endif
  output logic                  tc
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]  MAXC = W'(N - 1);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0]             pre, pre_nxt;
  logic [W-1:0]              count_nxt;
  logic                      tick_now, tick_nxt, tc_nxt;
  logic [DIGITS-1:0][3:0]    bcd_nxt;

  // With DIV=1 the prescaler is pinned at 0 == LAST, so every enabled
  // cycle is a tick.
  assign tick_now = en && (pre == LAST);

  always_comb begin
    pre_nxt   = pre;
    count_nxt = count_bin;
    tick_nxt  = 1'b0;
    tc_nxt    = 1'b0;
    if (clr) begin
      pre_nxt   = '0;
      count_nxt = '0;
    end else begin
      if (en) pre_nxt = tick_now ? '0 : pre + PW'(1);
      // A load swallows a coincident tick; the prescaler keeps its phase.
      if (load) begin
        count_nxt = (load_val > MAXC) ? MAXC : load_val;
      end else if (tick_now) begin
        tick_nxt = 1'b1;
        if (up) begin
          if (count_bin == MAXC) begin
            count_nxt = '0;
            tc_nxt    = 1'b1;
          end else begin
            count_nxt = count_bin + W'(1);
          end
        end else begin
          if (count_bin == '0) begin
            count_nxt = MAXC;
            tc_nxt    = 1'b1;
          end else begin
            count_nxt = count_bin - W'(1);
          end
        end
      end
    end
  end

  // Decimal digits of the next count, so BCD is registered alongside binary.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign bcd_nxt[i] = 4'((int'(count_nxt) / (10 ** i)) % 10);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre       <= '0;
      count_bin <= '0;
      count_bcd <= '0;
      tick_o    <= 1'b0;
      tc        <= 1'b0;
    end else begin
      pre       <= pre_nxt;
      count_bin <= count_nxt;
      count_bcd <= bcd_nxt;
      tick_o    <= tick_nxt;
      tc        <= tc_nxt;
    end
  end

`ifdef RTC_LAP_EN
  // Captures the count shown before this edge's update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lap_bcd   <= '0;
      lap_valid <= 1'b0;
    end else if (clr) begin
      lap_bcd   <= '0;
      lap_valid <= 1'b0;
    end else if (lap) begin
      lap_bcd   <= count_bcd;
      lap_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rt_bcd_counter.sv
module tb_rt_bcd_counter;
  localparam int CLK_HZ = 10, TICK_HZ = 1, N = 12, DIGITS = 2;
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int W = $clog2(N);

  logic clk = 1'b0, reset_n = 1'b0;
  logic en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic tick_o, tc;
  logic [W-1:0] count_bin;
  logic [4*DIGITS-1:0] count_bcd;
`ifdef RTC_LAP_EN
  logic lap = 1'b0;
  logic [4*DIGITS-1:0] lap_bcd;
  logic lap_valid;
`endif

  rt_bcd_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .N(N), .DIGITS(DIGITS)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .tick_o(tick_o), .count_bin(count_bin),
    .count_bcd(count_bcd),
`ifdef RTC_LAP_EN
    .lap(lap), .lap_bcd(lap_bcd), .lap_valid(lap_valid),
`endif
    .tc(tc));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: elapsed cycles in the current tick period, the count
  // as an integer, and the pulses expected after the last edge.
  int m_phase = 0, m_cnt = 0;
  bit m_tick = 0, m_tc = 0;
  int m_lap = 0;
  bit m_lapv = 0;

  function automatic int bcd_of(input int v);
    int r = 0;
    for (int i = 0; i < DIGITS; i++) r += ((v / (10 ** i)) % 10) << (4 * i);
    return r;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_tick = 0; m_tc = 0; m_lap = 0; m_lapv = 0;
  endtask

  task automatic model_edge();
    bit t;
    int shown = m_cnt;
    m_tick = 0; m_tc = 0;
    if (clr) begin
      m_phase = 0; m_cnt = 0; m_lap = 0; m_lapv = 0;
      return;
    end
`ifdef RTC_LAP_EN
    if (lap) begin m_lap = bcd_of(shown); m_lapv = 1; end
`endif
    t = en && (m_phase == DIV - 1);
    if (en) m_phase = (m_phase + 1) % DIV;
    if (load) m_cnt = (int'(load_val) < N) ? int'(load_val) : N - 1;
    else if (t) begin
      m_tick = 1;
      if (up) begin m_tc = (m_cnt == N - 1); m_cnt = (m_cnt + 1) % N; end
      else begin m_tc = (m_cnt == 0); m_cnt = (m_cnt + N - 1) % N; end
    end
  endtask

  task automatic check_all();
    chk("bin", 32'(count_bin), 32'(m_cnt));
    chk("bcd", 32'(count_bcd), 32'(bcd_of(m_cnt)));
    chk("tick", 32'(tick_o), 32'(m_tick));
    chk("tc", 32'(tc), 32'(m_tc));
`ifdef RTC_LAP_EN
    chk("lap_bcd", 32'(lap_bcd), 32'(m_lap));
    chk("lap_valid", 32'(lap_valid), 32'(m_lapv));
`endif
  endtask

  // One clock: model the edge, then sample 1 time unit later.
  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all();
    end
  endtask

  task automatic strobe_clr();
    clr = 1'b1; cyc(); clr = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_bin", 32'(count_bin), 0);
    chk("rst_bcd", 32'(count_bcd), 0);
    chk("rst_tick", 32'(tick_o), 0);
    chk("rst_tc", 32'(tc), 0);
    @(negedge clk); reset_n = 1'b1;

    // 1: free run upward through a wrap
    en = 1'b1; up = 1'b1;
    cyc(9);
    chk("first_tick_idle", 32'(tick_o), 0);
    cyc();
    chk("first_tick", 32'(tick_o), 1);
    chk("first_bcd", 32'(count_bcd), 32'h01);
    cyc(125 - 10);
    chk("wrap_up_bcd", 32'(count_bcd), 32'h00);

    // 2: downward wrap from 0
    strobe_clr();
    up = 1'b0;
    cyc(10);
    chk("dn_wrap_bin", 32'(count_bin), 11);
    chk("dn_wrap_bcd", 32'(count_bcd), 32'h11);
    chk("dn_wrap_tc", 32'(tc), 1);
    cyc(10);
    chk("dn_next_bcd", 32'(count_bcd), 32'h10);
    chk("dn_next_tc", 32'(tc), 0);

    // 3: loads, clamping, load on a tick edge
    up = 1'b1;
    strobe_clr();
    load = 1'b1; load_val = W'(15); cyc(); load = 1'b0;
    chk("load_clamp", 32'(count_bin), 11);
    load = 1'b1; load_val = W'(7); cyc(); load = 1'b0;
    chk("load7_bcd", 32'(count_bcd), 32'h07);
    cyc(7);                        // prescaler now at 9: next edge is a tick
    load = 1'b1; load_val = W'(7); cyc(); load = 1'b0;
    chk("load_tick_bin", 32'(count_bin), 7);
    chk("load_tick_tc", 32'(tc), 0);
    chk("load_tick_pulse", 32'(tick_o), 0);

    // 4: enable hold keeps prescaler phase
    strobe_clr();
    cyc(5);
    en = 1'b0; cyc(20);
    chk("hold_bin", 32'(count_bin), 0);
    en = 1'b1;
    cyc(4);
    chk("hold_early", 32'(tick_o), 0);
    cyc();
    chk("hold_tick", 32'(tick_o), 1);

    // 5: clr on a tick edge at count 11, then async reset mid-period
    strobe_clr();
    load = 1'b1; load_val = W'(11); cyc(); load = 1'b0;
    cyc(8);
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("clr_tick_bin", 32'(count_bin), 0);
    chk("clr_tick_tc", 32'(tc), 0);
    chk("clr_tick_pulse", 32'(tick_o), 0);
    cyc(9);
    chk("clr_next_early", 32'(tick_o), 0);
    cyc();
    chk("clr_next_tick", 32'(tick_o), 1);
    cyc(25);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_bin", 32'(count_bin), 0);
    chk("async_bcd", 32'(count_bcd), 0);
    @(negedge clk); reset_n = 1'b1;
    cyc(10);
    chk("post_rst_tick", 32'(tick_o), 1);

`ifdef RTC_LAP_EN
    // 6: lap capture
    strobe_clr();
    cyc(50);
    lap = 1'b1; cyc(); lap = 1'b0;
    chk("lap_cap", 32'(lap_bcd), 32'h05);
    chk("lap_v", 32'(lap_valid), 1);
    cyc(10);
    chk("lap_cont", 32'(count_bcd), 32'h06);
    strobe_clr();
    chk("lap_clr", 32'(lap_valid), 0);
`endif

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      up       = 1'($urandom_range(0, 1));
      clr      = ($urandom_range(0, 59) == 0);
      load     = ($urandom_range(0, 29) == 0);
      load_val = W'($urandom_range(0, (1 << W) - 1));
`ifdef RTC_LAP_EN
      lap      = ($urandom_range(0, 19) == 0);
`endif
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
